// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and the responder state type, imported by every AHB slave.
package ahb_lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } slave_state_e;

endpackage

// File: rtl/ahb_byte_strobe.sv
// Maps HSIZE and the low address bits onto 32-bit byte-lane enables and flags
// transfers that are misaligned or use an unsupported size.
module ahb_byte_strobe
    import ahb_lite_pkg::*;
(
    input  logic [2:0] size_i,
    input  logic [1:0] addr_i,
    output logic [3:0] strb_o,
    output logic       misalign_o
);

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        strb_o     = 4'b0000;
        misalign_o = 1'b0;
        case (size_i)
            HSIZE_BYTE: strb_o = 4'b0001 << addr_i;
            HSIZE_HALF: begin
                strb_o     = addr_i[1] ? 4'b1100 : 4'b0011;
                misalign_o = addr_i[0];
            end
            HSIZE_WORD: begin
                strb_o     = 4'b1111;
                misalign_o = |addr_i;
            end
            default:    misalign_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite word buffer responder with programmable wait states and a two-cycle
// ERROR response for out-of-range, misaligned or unsupported-size accesses.
module ahb_lite_sram_slave
    import ahb_lite_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [2:0]        HBURST,
    input  logic [3:0]        HPROT,
    input  logic              HMASTLOCK,
    input  logic [31:0]       HWDATA,
    input  logic              HREADY,
    output logic [31:0]       HRDATA,
    output logic              HREADYOUT,
    output logic              HRESP
);

    localparam int         IDX_W  = ADDR_W - 2;
    localparam int         MEM_AW = $clog2(DEPTH);
    localparam logic [2:0] WS     = 3'(WAIT_STATES);

    logic [31:0] mem [DEPTH];

    slave_state_e      state_q;
    logic [MEM_AW-1:0] idx_q;
    logic              write_q;
    logic [3:0]        strb_q;
    logic [2:0]        wait_q;
    logic              hreadyout_q;
    logic              hresp_q;
    logic [31:0]       rdata_q;

    logic [3:0]        strb;
    logic              misalign;
    logic              out_of_range;
    logic              accept;
    logic              commit;
    logic [MEM_AW-1:0] rd_idx;
    logic [31:0]       rd_word;
    logic              unused_ok;

    assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

    ahb_byte_strobe u_strobe (
        .size_i     (HSIZE),
        .addr_i     (HADDR[1:0]),
        .strb_o     (strb),
        .misalign_o (misalign)
    );

    assign out_of_range = {1'b0, HADDR[ADDR_W-1:2]} >= (IDX_W + 1)'(DEPTH);
    assign accept       = HSEL & HREADY & HTRANS[1];
    assign commit       = (state_q == S_DATA) && write_q && !HRESET;

    // Read word with the write retiring on this same edge merged in, so a read
    // issued right behind a write to the same word sees the new data.
    always_comb begin
        rd_idx  = (state_q == S_WAIT) ? idx_q : HADDR[MEM_AW+1:2];
        rd_word = mem[rd_idx];
        if (commit && (rd_idx == idx_q)) begin
            for (int i = 0; i < 4; i++) begin
                if (strb_q[i]) rd_word[8*i +: 8] = HWDATA[8*i +: 8];
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            write_q     <= 1'b0;
            strb_q      <= 4'b0000;
            wait_q      <= 3'd0;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            rdata_q     <= '0;
        end else begin
            rdata_q <= '0;
            case (state_q)
                S_WAIT: begin
                    wait_q <= wait_q - 3'd1;
                    if (wait_q == 3'd1) begin
                        state_q     <= S_DATA;
                        hreadyout_q <= 1'b1;
                        if (!write_q) rdata_q <= rd_word;
                    end
                end
                S_ERR1: begin
                    state_q     <= S_ERR2;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= HRESP_ERROR;
                end
                // IDLE, DATA and ERR2 all complete a beat and may take a new address phase.
                default: begin
                    state_q     <= S_IDLE;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= HRESP_OKAY;
                    if (accept) begin
                        idx_q   <= HADDR[MEM_AW+1:2];
                        write_q <= HWRITE;
                        strb_q  <= strb;
                        if (misalign || out_of_range) begin
                            state_q     <= S_ERR1;
                            hreadyout_q <= 1'b0;
                            hresp_q     <= HRESP_ERROR;
                        end else if (WAIT_STATES > 0) begin
                            state_q     <= S_WAIT;
                            wait_q      <= WS;
                            hreadyout_q <= 1'b0;
                        end else begin
                            state_q <= S_DATA;
                            if (!HWRITE) rdata_q <= rd_word;
                        end
                    end
                end
            endcase
        end
    end

    // NOTE: the array is deliberately left out of reset so it maps onto RAM and keeps its contents across HRESET.
    always_ff @(posedge HCLK) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (strb_q[i]) mem[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
            end
        end
    end

    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;
    assign HRDATA    = rdata_q;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Directed bench for ahb_lite_sram_slave: one instance with one wait state, one with none,
// checked every cycle against a transfer-level model of the responder.
module tb_ahb_lite_sram_slave;
    import ahb_lite_pkg::*;

    typedef struct packed {
        logic        rdy;
        logic        resp;
        logic [31:0] data;
        logic        is_rd;
    } exp_t;

    logic        clk;
    logic        hreset    [2];
    logic        hsel      [2];
    logic [11:0] haddr     [2];
    logic [1:0]  htrans    [2];
    logic        hwrite    [2];
    logic [2:0]  hsize     [2];
    logic [31:0] hwdata    [2];
    logic        hready    [2];
    logic        hold      [2];
    logic [31:0] hrdata    [2];
    logic        hreadyout [2];
    logic        hresp     [2];
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic        hmastlock;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 0;

    exp_t        q0 [$];
    exp_t        q1 [$];
    logic [31:0] mmem    [2][256];
    logic [31:0] last_rd [2];

    logic        b_sel   [16];
    logic [1:0]  b_trans [16];
    logic        b_write [16];
    logic [11:0] b_addr  [16];
    logic [2:0]  b_size  [16];
    logic [31:0] b_wdata [16];
    int          n_beats = 0;

    assign hready[0] = hold[0] ? 1'b0 : hreadyout[0];
    assign hready[1] = hold[1] ? 1'b0 : hreadyout[1];

    ahb_lite_sram_slave #(.ADDR_W(12), .DEPTH(256), .WAIT_STATES(1)) u_dut0 (
        .HCLK(clk), .HRESET(hreset[0]), .HSEL(hsel[0]), .HADDR(haddr[0]), .HTRANS(htrans[0]),
        .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HBURST(hburst), .HPROT(hprot),
        .HMASTLOCK(hmastlock), .HWDATA(hwdata[0]), .HREADY(hready[0]),
        .HRDATA(hrdata[0]), .HREADYOUT(hreadyout[0]), .HRESP(hresp[0])
    );

    ahb_lite_sram_slave #(.ADDR_W(12), .DEPTH(256), .WAIT_STATES(0)) u_dut1 (
        .HCLK(clk), .HRESET(hreset[1]), .HSEL(hsel[1]), .HADDR(haddr[1]), .HTRANS(htrans[1]),
        .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HBURST(hburst), .HPROT(hprot),
        .HMASTLOCK(hmastlock), .HWDATA(hwdata[1]), .HREADY(hready[1]),
        .HRDATA(hrdata[1]), .HREADYOUT(hreadyout[1]), .HRESP(hresp[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic rdy, input logic resp, input logic [31:0] data,
                                input logic is_rd);
        exp_t e;
        e.rdy = rdy; e.resp = resp; e.data = data; e.is_rd = is_rd;
        return e;
    endfunction

    function automatic bit illegal(input logic [11:0] a, input logic [2:0] s);
        if ((int'(a) >> 2) >= 256) return 1'b1;
        if (s > 3'd2) return 1'b1;
        if (s == 3'd1 && a[0]) return 1'b1;
        if (s == 3'd2 && a[1:0] != 2'b00) return 1'b1;
        return 1'b0;
    endfunction

    task automatic push(input int d, input exp_t e);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Transfer-level model: what the slave must show for each beat, in order.
    task automatic expect_beat(input int d, input int i);
        int ws;
        int idx;
        ws  = (d == 0) ? 1 : 0;
        idx = int'(b_addr[i]) >> 2;
        if (!(b_sel[i] && b_trans[i][1])) begin
            push(d, mk(1'b1, 1'b0, 32'h0, 1'b0));
        end else if (illegal(b_addr[i], b_size[i])) begin
            push(d, mk(1'b0, 1'b1, 32'h0, 1'b0));
            push(d, mk(1'b1, 1'b1, 32'h0, 1'b0));
        end else begin
            repeat (ws) push(d, mk(1'b0, 1'b0, 32'h0, 1'b0));
            if (b_write[i]) begin
                for (int k = 0; k < (1 << b_size[i]); k++) begin
                    int lane;
                    lane = int'(b_addr[i][1:0]) + k;
                    mmem[d][idx][8*lane +: 8] = b_wdata[i][8*lane +: 8];
                end
                push(d, mk(1'b1, 1'b0, 32'h0, 1'b0));
            end else begin
                push(d, mk(1'b1, 1'b0, mmem[d][idx], 1'b1));
            end
        end
    endtask

    task automatic add_beat(input logic sel, input logic [1:0] tr, input logic wr,
                            input logic [11:0] a, input logic [2:0] sz, input logic [31:0] wd);
        b_sel[n_beats] = sel;  b_trans[n_beats] = tr; b_write[n_beats] = wr;
        b_addr[n_beats] = a;   b_size[n_beats] = sz;  b_wdata[n_beats] = wd;
        n_beats++;
    endtask

    task automatic drive(input int d, input int i);
        hsel[d] = b_sel[i]; htrans[d] = b_trans[i]; hwrite[d] = b_write[i];
        haddr[d] = b_addr[i]; hsize[d] = b_size[i];
    endtask

    task automatic go_idle(input int d);
        hsel[d] = 1'b0; htrans[d] = HTRANS_IDLE; hwrite[d] = 1'b0;
    endtask

    // Pipelined master: each beat's address phase overlaps the previous data phase.
    task automatic run(input int d, input int stall);
        bit r;
        int guard;
        #1;
        drive(d, 0);
        if (stall > 0) begin
            hold[d] = 1'b1;
            repeat (stall) @(posedge clk);
            #1 hold[d] = 1'b0;
        end
        @(posedge clk);
        for (int i = 0; i < n_beats; i++) begin
            #1;
            expect_beat(d, i);
            hwdata[d] = b_wdata[i];
            if (i + 1 < n_beats) drive(d, i + 1);
            else                 go_idle(d);
            guard = 0;
            do begin
                @(negedge clk);
                r = hreadyout[d];
                @(posedge clk);
                guard++;
            end while (!r && guard < 20);
            if (!r) begin
                n_checks++;
                n_errors++;
                $display("FAIL d%0d beat %0d timeout: HREADYOUT still 0 after %0d cycles", d, i, guard);
            end
        end
        n_beats = 0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                e = mk(1'b1, 1'b0, 32'h0, 1'b0);
                if (d == 0 && q0.size() > 0) e = q0.pop_front();
                if (d == 1 && q1.size() > 0) e = q1.pop_front();
                check($sformatf("d%0d_hreadyout", d), 32'(hreadyout[d]), 32'(e.rdy));
                check($sformatf("d%0d_hresp", d), 32'(hresp[d]), 32'(e.resp));
                check($sformatf("d%0d_hrdata", d), hrdata[d], e.data);
                if (e.is_rd) last_rd[d] = hrdata[d];
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        hburst = 3'b000; hprot = 4'b0011; hmastlock = 1'b0;
        for (int d = 0; d < 2; d++) begin
            hreset[d] = 1'b1; hold[d] = 1'b0; hwdata[d] = '0;
            haddr[d] = '0; hsize[d] = HSIZE_WORD; last_rd[d] = '0;
            go_idle(d);
        end
        repeat (3) @(posedge clk);
        #1;
        hreset[0] = 1'b0;
        hreset[1] = 1'b0;
        chk_en    = 1'b1;
        @(negedge clk);
        check("reset_hreadyout", 32'(hreadyout[0]), 32'd1);
        check("reset_hresp", 32'(hresp[1]), 32'd0);
        check("reset_hrdata", hrdata[0], 32'h0);

        // 1: word write then read, one wait state each
        add_beat(1'b1, HTRANS_NONSEQ, 1'b1, 12'h010, HSIZE_WORD, 32'hDEADBEEF);
        add_beat(1'b1, HTRANS_NONSEQ, 1'b0, 12'h010, HSIZE_WORD, 32'h0);
        run(0, 0);
        check("t1_read", last_rd[0], 32'hDEADBEEF);

        // 2: byte and halfword lane merging
        add_beat(1'b1, HTRANS_NONSEQ, 1'b1, 12'h010, HSIZE_WORD, 32'h11223344);
        add_beat(1'b1, HTRANS_NONSEQ, 1'b1, 12'h013, HSIZE_BYTE, 32'hAA000000);
        add_beat(1'b1, HTRANS_NONSEQ, 1'b0, 12'h010, HSIZE_WORD, 32'h0);
        run(0, 0);
        check("t2_byte", last_rd[0], 32'hAA223344);
        add_beat(1'b1, HTRANS_NONSEQ, 1'b1, 12'h010, HSIZE_HALF, 32'h00005566);
        add_beat(1'b1, HTRANS_NONSEQ, 1'b0, 12'h010, HSIZE_WORD, 32'h0);
        run(0, 0);
        check("t2_half", last_rd[0], 32'hAA225566);
        check("t2_model", mmem[0][4], 32'hAA225566);

        // 3: misaligned, out-of-range and bad-size accesses, then confirm memory intact
        add_beat(1'b1, HTRANS_NONSEQ, 1'b0, 12'h002, HSIZE_WORD, 32'h0);
        add_beat(1'b1, HTRANS_NONSEQ, 1'b0, 12'h400, HSIZE_WORD, 32'h0);
        add_beat(1'b1, HTRANS_BUSY,   1'b0, 12'h404, HSIZE_WORD, 32'h0);
        add_beat(1'b1, HTRANS_NONSEQ, 1'b1, 12'h010, 3'b011,     32'h0);
        add_beat(1'b1, HTRANS_NONSEQ, 1'b1, 12'h011, HSIZE_HALF, 32'h0);
        add_beat(1'b1, HTRANS_NONSEQ, 1'b0, 12'h010, HSIZE_WORD, 32'h0);
        run(0, 0);
        check("t3_unchanged", last_rd[0], 32'hAA225566);

        // 5: reset while a write to 0x020 is in its wait state
        add_beat(1'b1, HTRANS_NONSEQ, 1'b1, 12'h020, HSIZE_WORD, 32'h0BADC0DE);
        run(0, 0);
        #1;
        hsel[0] = 1'b1; htrans[0] = HTRANS_NONSEQ; hwrite[0] = 1'b1;
        haddr[0] = 12'h020; hsize[0] = HSIZE_WORD;
        @(posedge clk);
        #1;
        q0.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0));
        hwdata[0] = 32'h11111111;
        go_idle(0);
        hreset[0] = 1'b1;
        @(posedge clk);
        #1 hreset[0] = 1'b0;
        @(negedge clk);
        check("t5_rdy_after_reset", 32'(hreadyout[0]), 32'd1);
        check("t5_resp_after_reset", 32'(hresp[0]), 32'd0);
        add_beat(1'b1, HTRANS_NONSEQ, 1'b0, 12'h020, HSIZE_WORD, 32'h0);
        run(0, 0);
        check("t5_old_value", last_rd[0], 32'h0BADC0DE);

        // 6: address phase held while another slave stalls HREADY
        add_beat(1'b1, HTRANS_NONSEQ, 1'b1, 12'h030, HSIZE_WORD, 32'h12345678);
        add_beat(1'b1, HTRANS_NONSEQ, 1'b0, 12'h030, HSIZE_WORD, 32'h0);
        run(0, 3);
        check("t6_single_write", last_rd[0], 32'h12345678);

        // 4: zero wait states, SEQ bursts, BUSY/IDLE beats and write-then-read forwarding
        for (int k = 0; k < 4; k++)
            add_beat(1'b1, (k == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 1'b1, 12'(4 * k), HSIZE_WORD, 32'(k));
        for (int k = 0; k < 4; k++) begin
            add_beat(1'b1, (k == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 1'b0, 12'(4 * k), HSIZE_WORD, 32'h0);
            if (k == 1) add_beat(1'b1, HTRANS_BUSY, 1'b0, 12'h008, HSIZE_WORD, 32'h0);
        end
        add_beat(1'b1, HTRANS_IDLE,   1'b0, 12'h000, HSIZE_WORD, 32'h0);
        add_beat(1'b1, HTRANS_NONSEQ, 1'b1, 12'h040, HSIZE_WORD, 32'hCAFEF00D);
        add_beat(1'b1, HTRANS_NONSEQ, 1'b0, 12'h040, HSIZE_WORD, 32'h0);
        run(1, 0);
        check("t4_forward", last_rd[1], 32'hCAFEF00D);
        check("t4_model", mmem[1][3], 32'h00000003);

        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
